// File: rtl/cvp14_pkg.sv
// ---------------------------------------------------------------------------
// cvp14_pkg
// Definitions shared by the CVP14 core and its system-memory responder:
//   - DATA_W        : processor bus width (16 bits)
//   - smem_state_t  : responder FSM encoding (IDLE / RD_WAIT)
//   - OP_*          : opcode constants shared with the core's decoder
// ---------------------------------------------------------------------------
package cvp14_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } smem_state_t;

    // Opcode field (instruction bits [15:12]) as decoded by the core.
    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VDOT = 4'h1;
    localparam logic [3:0] OP_SMUL = 4'h2;
    localparam logic [3:0] OP_SST  = 4'h3;
    localparam logic [3:0] OP_VLD  = 4'h4;
    localparam logic [3:0] OP_VST  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SLH  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_NOP  = 4'hF;

endpackage

// File: rtl/smem_array.sv
// ---------------------------------------------------------------------------
// smem_array
// 2^AW x DW storage for the system-memory responder. Synchronous write,
// combinational (asynchronous) read; contents are never cleared.
// Ports:
//   clk      : clock, writes on posedge
//   i_we     : write enable
//   i_waddr  : write word address
//   i_wdata  : write data
//   i_raddr  : read word address
//   o_rdata  : read data, combinational from i_raddr
// ---------------------------------------------------------------------------
module smem_array #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sys_mem_resp.sv
// ---------------------------------------------------------------------------
// sys_mem_resp
// Target end of the CVP14 Addr/RD/WR bus. Level-held RD/WR strobes are turned
// into single accesses by rising-edge detection. Writes complete in one cycle;
// reads return data READ_LAT cycles after the RD edge is sampled. Protocol
// violations (out-of-range address, simultaneous RD/WR edges, new strobe edge
// while a read is pending, protected write) set a sticky Err.
//
// Optional build macro: SMEM_WRPROT_EN -- when defined, in-range writes below
// PROT_BASE are suppressed (Err set, Ack still pulses).
//
// Ports:
//   Clk1   : clock
//   Reset  : synchronous, active-high reset
//   Addr   : word address from the core
//   RD/WR  : level read / write strobes
//   WData  : write data
//   RData  : read data, held between reads
//   Ack    : one-cycle pulse when an access completes
//   Busy   : high while a read is pending
//   Err    : sticky error flag, cleared only by Reset
// ---------------------------------------------------------------------------
module sys_mem_resp
    import cvp14_pkg::*;
#(
    parameter int                AW        = 10,
    parameter int                READ_LAT  = 1,
    parameter logic [DATA_W-1:0] PROT_BASE = 16'h0040
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              Ack,
    output logic              Busy,
    output logic              Err
);

    smem_state_t       r_state,    w_state_next;
    logic [2:0]        r_cnt,      w_cnt_next;
    logic [AW-1:0]     r_addr,     w_addr_next;
    logic              r_addr_oor, w_addr_oor_next;
    logic [DATA_W-1:0] r_rdata,    w_rdata_next;
    logic              r_ack,      w_ack_next;
    logic              r_busy,     w_busy_next;
    logic              r_err,      w_err_next;
    logic              r_rd_q;
    logic              r_wr_q;

    logic              w_rd_rise;
    logic              w_wr_rise;
    logic              w_addr_oor;
    logic              w_prot_hit;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_rd_rise  = RD & ~r_rd_q;
    assign w_wr_rise  = WR & ~r_wr_q;
    assign w_addr_oor = |Addr[DATA_W-1:AW];

`ifdef SMEM_WRPROT_EN
    assign w_prot_hit = (Addr < PROT_BASE);
`else
    // Write protection is compiled out; PROT_BASE has no effect here.
    assign w_prot_hit = 1'b0 & (Addr < PROT_BASE);
`endif

    // Write port uses the live bus address/data: writes only ever happen on
    // the edge cycle, so nothing needs to be latched for them.
    smem_array #(
        .AW (AW),
        .DW (DATA_W)
    ) u_array (
        .clk     (Clk1),
        .i_we    (w_mem_we & ~Reset),
        .i_waddr (Addr[AW-1:0]),
        .i_wdata (WData),
        .i_raddr (r_addr),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_addr_next     = r_addr;
        w_addr_oor_next = r_addr_oor;
        w_rdata_next    = r_rdata;
        w_ack_next      = 1'b0;
        w_busy_next     = r_busy;
        w_err_next      = r_err;
        w_mem_we        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_wr_rise) begin
                    // A write always acknowledges, even when it is refused.
                    w_ack_next = 1'b1;
                    if (w_addr_oor || w_prot_hit) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_mem_we = 1'b1;
                    end
                    // Read edge coinciding with the write is dropped.
                    if (w_rd_rise) begin
                        w_err_next = 1'b1;
                    end
                end else if (w_rd_rise) begin
                    if (WR) begin
                        // Read edge while a write is still held: not served.
                        w_err_next = 1'b1;
                    end else begin
                        w_addr_next     = Addr[AW-1:0];
                        w_addr_oor_next = w_addr_oor;
                        w_cnt_next      = 3'(READ_LAT - 1);
                        w_busy_next     = 1'b1;
                        w_state_next    = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (w_rd_rise || w_wr_rise) begin
                    w_err_next = 1'b1;
                end
                if (r_cnt != 3'd0) begin
                    w_cnt_next = r_cnt - 3'd1;
                end else begin
                    if (r_addr_oor) begin
                        w_rdata_next = '0;
                        w_err_next   = 1'b1;
                    end else begin
                        w_rdata_next = w_mem_rdata;
                    end
                    w_ack_next   = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_addr_oor <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_q     <= 1'b0;
            r_wr_q     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_addr     <= w_addr_next;
            r_addr_oor <= w_addr_oor_next;
            r_rdata    <= w_rdata_next;
            r_ack      <= w_ack_next;
            r_busy     <= w_busy_next;
            r_err      <= w_err_next;
            r_rd_q     <= RD;
            r_wr_q     <= WR;
        end
    end

    assign RData = r_rdata;
    assign Ack   = r_ack;
    assign Busy  = r_busy;
    assign Err   = r_err;

endmodule

// File: tb/tb_sys_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_sys_mem_resp
// Three responders (READ_LAT = 1, 3, 4) share one bus so every access is seen
// by all of them; each is checked against a word-level memory/flag model.
// Build with +define+SMEM_WRPROT_EN to exercise the write-protection variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sys_mem_resp;

    localparam int NI = 3;
`ifdef SMEM_WRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif
    localparam logic [15:0] PROT_BASE_M = 16'h0040;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] WData;
    logic [15:0] rdata [NI];
    logic [NI-1:0] ack;
    logic [NI-1:0] busy;
    logic [NI-1:0] err;

    always #5 Clk1 = ~Clk1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sys_mem_resp #(
            .AW        (10),
            .READ_LAT  ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4)),
            .PROT_BASE (16'h0040)
        ) u_dut (
            .Clk1  (Clk1),
            .Reset (Reset),
            .Addr  (Addr),
            .RD    (RD),
            .WR    (WR),
            .WData (WData),
            .RData (rdata[gi]),
            .Ack   (ack[gi]),
            .Busy  (busy[gi]),
            .Err   (err[gi])
        );
    end

    // Reference model
    logic [15:0] mem_m [1024];
    bit          vld_m [1024];
    bit          err_m;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge Clk1);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                            input int hold, input logic [15:0] d_late);
        bit oor;
        bit prot;
        oor  = (a[15:10] != 6'd0);
        prot = PROT_EN && (a < PROT_BASE_M);
        $display("WRITE addr=%h data=%h hold=%0d", a, d, hold);
        WR = 1'b1; Addr = a; WData = d;
        tick();
        if (oor || prot) err_m = 1'b1;
        else begin
            mem_m[a[9:0]] = d;
            vld_m[a[9:0]] = 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (ack[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_ack inst%0d: got %b want 1", i, ack[i]);
            end
            n_checks++;
            if (busy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_busy inst%0d: got %b want 0", i, busy[i]);
            end
        end
        // Later bus changes must not affect the accepted write.
        WData = d_late;
        Addr  = 16'($urandom);
        for (int c = 1; c <= hold; c++) begin
            if (c == hold) WR = 1'b0;
            tick();
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (ack[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_extra_ack inst%0d cyc%0d: got %b want 0", i, c, ack[i]);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (err[i] !== err_m) begin
                n_fail++;
                $display("FAIL wr_err inst%0d: got %b want %b", i, err[i], err_m);
            end
        end
        Addr = 16'h0;
    endtask

    task automatic do_read(input logic [15:0] a, input int hold);
        bit          oor;
        bit          chk;
        logic [15:0] exp_d;
        int          nack [NI];
        oor   = (a[15:10] != 6'd0);
        chk   = oor || vld_m[a[9:0]];
        exp_d = oor ? 16'h0000 : mem_m[a[9:0]];
        $display("READ  addr=%h hold=%0d expect=%h", a, hold, exp_d);
        for (int i = 0; i < NI; i++) nack[i] = 0;
        RD = 1'b1; Addr = a;
        tick();
        Addr = 16'($urandom);
        for (int c = 0; c <= 6; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (ack[i] === 1'b1) nack[i]++;
                n_checks++;
                if (ack[i] !== (c == lat_of(i))) begin
                    n_fail++;
                    $display("FAIL rd_ack inst%0d cyc%0d: got %b want %b", i, c, ack[i], (c == lat_of(i)));
                end
                n_checks++;
                if (busy[i] !== (c < lat_of(i))) begin
                    n_fail++;
                    $display("FAIL rd_busy inst%0d cyc%0d: got %b want %b", i, c, busy[i], (c < lat_of(i)));
                end
                if (chk && c >= lat_of(i)) begin
                    n_checks++;
                    if (rdata[i] !== exp_d) begin
                        n_fail++;
                        $display("FAIL rd_data inst%0d cyc%0d: got %h want %h", i, c, rdata[i], exp_d);
                    end
                end
            end
            if (c == hold - 1) RD = 1'b0;
            if (c < 6) tick();
        end
        if (oor) err_m = 1'b1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (nack[i] != 1) begin
                n_fail++;
                $display("FAIL rd_ack_count inst%0d: got %0d want 1", i, nack[i]);
            end
            n_checks++;
            if (err[i] !== err_m) begin
                n_fail++;
                $display("FAIL rd_err inst%0d: got %b want %b", i, err[i], err_m);
            end
        end
        Addr = 16'h0;
    endtask

    task automatic apply_reset(input int cycles);
        Reset = 1'b1; RD = 1'b0; WR = 1'b0;
        for (int c = 0; c < cycles; c++) tick();
        Reset = 1'b0;
        err_m = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; RD = 1'b0; WR = 1'b0; Addr = 16'h0; WData = 16'h0;
        for (int c = 0; c < 3; c++) tick();
        $display("RESET check");
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rdata[i] !== 16'h0 || ack[i] !== 1'b0 || busy[i] !== 1'b0 || err[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got rdata=%h ack=%b busy=%b err=%b want 0/0/0/0",
                         i, rdata[i], ack[i], busy[i], err[i]);
            end
        end
        Reset = 1'b0;
        err_m = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        do_write(16'h0012, 16'hBEEF, 1, 16'hBEEF);
        do_read(16'h0012, 3);
    endtask

    task automatic test_latency();
        do_write(16'h0005, 16'h1234, 1, 16'h1234);
        do_read(16'h0005, 1);
        do_write(16'h03FF, 16'hC0DE, 2, 16'h0000);
        do_read(16'h03FF, 2);
    endtask

    task automatic test_held_wr();
        do_write(16'h0050, 16'h0001, 4, 16'h0002);
        do_read(16'h0050, 1);
    endtask

    task automatic test_out_of_range();
        do_write(16'h0000, 16'h5A5A, 1, 16'h5A5A);
        do_read(16'h0400, 1);
        do_write(16'h8000, 16'hFFFF, 1, 16'hFFFF);
        do_read(16'h0000, 1);
    endtask

    task automatic test_conflict();
        $display("CONFLICT addr=0020 data=00aa");
        RD = 1'b1; WR = 1'b1; Addr = 16'h0020; WData = 16'h00AA;
        tick();
        mem_m[10'h020] = 16'h00AA;
        vld_m[10'h020] = 1'b1;
        if (PROT_EN) vld_m[10'h020] = 1'b0;
        err_m = 1'b1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (ack[i] !== 1'b1 || busy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL conflict_wr_ack inst%0d: got ack=%b busy=%b want 1/0", i, ack[i], busy[i]);
            end
        end
        RD = 1'b0; WR = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (ack[i] !== 1'b0 || busy[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL conflict_no_read inst%0d cyc%0d: got ack=%b busy=%b want 0/0", i, c, ack[i], busy[i]);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (err[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL conflict_err inst%0d: got %b want 1", i, err[i]);
            end
        end
        do_read(16'h0020, 1);
        $display("RESET clears Err");
        apply_reset(1);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (err[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_clears_err inst%0d: got %b want 0", i, err[i]);
            end
        end
    endtask

    task automatic test_abort();
        $display("ABORT read addr=0012 with reset during wait");
        RD = 1'b1; Addr = 16'h0012;
        tick();
        RD = 1'b0;
        tick();
        tick();
        // Slowest responder is still waiting; reset must abort it.
        Reset = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (ack[i] !== 1'b0 || busy[i] !== 1'b0 || rdata[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL abort_state inst%0d: got ack=%b busy=%b rdata=%h want 0/0/0000",
                         i, ack[i], busy[i], rdata[i]);
            end
        end
        Reset = 1'b0;
        err_m = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (ack[i] !== 1'b0 || busy[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_no_ack inst%0d cyc%0d: got ack=%b busy=%b want 0/0", i, c, ack[i], busy[i]);
                end
            end
        end
    endtask

    task automatic test_protect();
`ifdef SMEM_WRPROT_EN
        do_write(16'h0010, 16'h7777, 1, 16'h7777);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (err[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL prot_err inst%0d: got %b want 1", i, err[i]);
            end
        end
        do_write(16'h0040, 16'h4040, 1, 16'h4040);
        do_read(16'h0040, 1);
`else
        do_write(16'h0010, 16'h7777, 1, 16'h7777);
        do_read(16'h0010, 1);
`endif
    endtask

    task automatic test_random();
        logic [15:0] pool [8];
        int          op;
        apply_reset(1);
        for (int k = 0; k < 8; k++) pool[k] = 16'($urandom_range(0, 1023));
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 3)
                do_write(pool[$urandom_range(0, 7)], 16'($urandom),
                         $urandom_range(1, 3), 16'($urandom));
            else if (op <= 7)
                do_read(pool[$urandom_range(0, 7)], $urandom_range(1, 3));
            else if (op == 8)
                do_write(16'h0400 | 16'($urandom), 16'($urandom), 1, 16'($urandom));
            else
                do_read(16'h0400 | 16'($urandom), 1);
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) vld_m[k] = 1'b0;
        err_m = 1'b0;
        Reset = 1'b1; RD = 1'b0; WR = 1'b0; Addr = 16'h0; WData = 16'h0;
        test_reset();
        test_write_read();
        test_latency();
        test_held_wr();
        test_out_of_range();
        test_conflict();
        test_abort();
        test_protect();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
